// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/decoder memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF         = 32;
   localparam int unsigned DATA_W_DEF         = 32;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

   typedef enum logic [1:0] {
      IDLE,
      RD_FETCH,
      RD_DATA,
      WR_DATA
   } arb_state_e;

   typedef enum logic {
      REQ_FETCH = 1'b0,
      REQ_DATA  = 1'b1
   } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side bundle of mem_port_arbiter.
// master = arbiter view, slave = fetch/decoder/memory-wrapper view.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic              fetch_req_in;
   logic [ADDR_W-1:0] fetch_addr_in;
   logic              fetch_gnt_out;
   logic              fetch_rvalid_out;
   logic [DATA_W-1:0] fetch_rdata_out;
   logic              data_req_in;
   logic              data_we_in;
   logic [ADDR_W-1:0] data_addr_in;
   logic [DATA_W-1:0] data_wdata_in;
   logic              data_gnt_out;
   logic              data_rvalid_out;
   logic              data_wdone_out;
   logic [DATA_W-1:0] data_rdata_out;
   logic [ADDR_W-1:0] mem_addr_out;
   logic [DATA_W-1:0] mem_wdata_out;
   logic              mem_read_en_out;
   logic              mem_write_en_out;
   logic [DATA_W-1:0] mem_rdata_in;
   logic              mem_output_valid_in;
   logic              mem_write_ready_in;
   logic              stall_fetch_out;
   logic              stall_decoder_out;
   logic              timeout_err_out;

   modport master (
      input  fetch_req_in, fetch_addr_in,
      input  data_req_in, data_we_in, data_addr_in, data_wdata_in,
      input  mem_rdata_in, mem_output_valid_in, mem_write_ready_in,
      output fetch_gnt_out, fetch_rvalid_out, fetch_rdata_out,
      output data_gnt_out, data_rvalid_out, data_wdone_out, data_rdata_out,
      output mem_addr_out, mem_wdata_out, mem_read_en_out, mem_write_en_out,
      output stall_fetch_out, stall_decoder_out, timeout_err_out
   );

   modport slave (
      output fetch_req_in, fetch_addr_in,
      output data_req_in, data_we_in, data_addr_in, data_wdata_in,
      output mem_rdata_in, mem_output_valid_in, mem_write_ready_in,
      input  fetch_gnt_out, fetch_rvalid_out, fetch_rdata_out,
      input  data_gnt_out, data_rvalid_out, data_wdone_out, data_rdata_out,
      input  mem_addr_out, mem_wdata_out, mem_read_en_out, mem_write_en_out,
      input  stall_fetch_out, stall_decoder_out, timeout_err_out
   );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Two-way fair picker: turn bit decides contested grants and flips to the loser.
module mem_arb_rr_pick
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic turn_q, turn_d;

   always_comb begin
      gnt_o  = '0;
      turn_d = turn_q;
      if (en_i) begin
         if (req_i[REQ_FETCH] && req_i[REQ_DATA]) begin
            if (turn_q == REQ_FETCH) gnt_o[REQ_FETCH] = 1'b1;
            else                     gnt_o[REQ_DATA]  = 1'b1;
            turn_d = ~turn_q;
         end else begin
            gnt_o = req_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) turn_q <= REQ_FETCH;
      else        turn_q <= turn_d;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer for instruction fetch and decoder load/store.
// Optional busy-cycle abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W         = ADDR_W_DEF,
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.master bus
);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] frdata_q, frdata_d, drdata_q, drdata_d;
   logic              fgnt_q, fgnt_d, dgnt_q, dgnt_d;
   logic              frv_q, frv_d, drv_q, drv_d, dwd_q, dwd_d;
   logic [1:0]        req_eff, gnt;
   logic              abort;

   // A requester is ignored in the cycle its own response pulse is out.
   assign req_eff[REQ_FETCH] = bus.fetch_req_in & ~frv_q;
   assign req_eff[REQ_DATA]  = bus.data_req_in & ~(drv_q | dwd_q);

   mem_arb_rr_pick u_pick (
      .clk   (clk),
      .reset (reset),
      .en_i  (state_q == IDLE),
      .req_i (req_eff),
      .gnt_o (gnt)
   );

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             resp;

   always_comb begin
      resp  = ((state_q == RD_FETCH || state_q == RD_DATA) && bus.mem_output_valid_in) ||
              ((state_q == WR_DATA) && bus.mem_write_ready_in);
      abort = (state_q != IDLE) && !resp && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      cnt_d = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
      err_d = err_q | abort;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus.timeout_err_out = err_q;
`else
   assign abort               = 1'b0;
   assign bus.timeout_err_out = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      frdata_d = frdata_q;
      drdata_d = drdata_q;
      fgnt_d   = 1'b0;
      dgnt_d   = 1'b0;
      frv_d    = 1'b0;
      drv_d    = 1'b0;
      dwd_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gnt[REQ_FETCH]) begin
               state_d = RD_FETCH;
               addr_d  = bus.fetch_addr_in;
               fgnt_d  = 1'b1;
            end else if (gnt[REQ_DATA]) begin
               state_d = bus.data_we_in ? WR_DATA : RD_DATA;
               addr_d  = bus.data_addr_in;
               dgnt_d  = 1'b1;
               if (bus.data_we_in) wdata_d = bus.data_wdata_in;
            end
         end
         RD_FETCH: begin
            if (bus.mem_output_valid_in || abort) begin
               frdata_d = bus.mem_output_valid_in ? bus.mem_rdata_in : '0;
               frv_d    = 1'b1;
               state_d  = IDLE;
            end
         end
         RD_DATA: begin
            if (bus.mem_output_valid_in || abort) begin
               drdata_d = bus.mem_output_valid_in ? bus.mem_rdata_in : '0;
               drv_d    = 1'b1;
               state_d  = IDLE;
            end
         end
         WR_DATA: begin
            if (bus.mem_write_ready_in || abort) begin
               dwd_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         frdata_q <= '0;
         drdata_q <= '0;
         fgnt_q   <= 1'b0;
         dgnt_q   <= 1'b0;
         frv_q    <= 1'b0;
         drv_q    <= 1'b0;
         dwd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         frdata_q <= frdata_d;
         drdata_q <= drdata_d;
         fgnt_q   <= fgnt_d;
         dgnt_q   <= dgnt_d;
         frv_q    <= frv_d;
         drv_q    <= drv_d;
         dwd_q    <= dwd_d;
      end
   end

   assign bus.fetch_gnt_out     = fgnt_q;
   assign bus.fetch_rvalid_out  = frv_q;
   assign bus.fetch_rdata_out   = frdata_q;
   assign bus.data_gnt_out      = dgnt_q;
   assign bus.data_rvalid_out   = drv_q;
   assign bus.data_wdone_out    = dwd_q;
   assign bus.data_rdata_out    = drdata_q;
   assign bus.mem_addr_out      = addr_q;
   assign bus.mem_wdata_out     = wdata_q;
   assign bus.mem_read_en_out   = (state_q == RD_FETCH) || (state_q == RD_DATA);
   assign bus.mem_write_en_out  = (state_q == WR_DATA);
   assign bus.stall_fetch_out   = bus.fetch_req_in & ~frv_q;
   assign bus.stall_decoder_out = bus.data_req_in & ~(drv_q | dwd_q);

endmodule
